mul_div_unit: RTL

- Iterative 32-bit multiply/divide unit with HI/LO result registers for MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Sits directly downstream of the register file. operand_a and operand_b are fed from read_data_1 and read_data_2.
- HI/LO are read by the writeback mux (MFHI/MFLO).
- Multi-cycle with a start/busy/done handshake, so the pipeline stalls on busy.

---
 rtl/mul_div_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (MULT[U]/DIV[U], MTHI/MTLO).
// Define MUL_DIV_SIGNED_EN to enable signed MULT/DIV via an extra FIXUP state.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
`ifdef MUL_DIV_SIGNED_EN
    StFixup,
`endif
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;  // product upper half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;    // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] b_q, b_d;      // multiplicand / divisor
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef MUL_DIV_SIGNED_EN
  logic signed_q, signed_d;
  logic div_q, div_d;
  logic neg_q, neg_d;
  logic rem_neg_q, rem_neg_d;
  logic sign_a, sign_b;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign sign_a   = op[1] & operand_a[WIDTH-1];
  assign sign_b   = op[1] & operand_b[WIDTH-1];
  assign a_mag    = sign_a ? -operand_a : operand_a;
  assign b_mag    = sign_b ? -operand_b : operand_b;
  assign prod     = {acc_q, mq_q};
  assign prod_neg = -prod;
`else
  logic unused_op1;
  assign unused_op1 = op[1];
  assign a_mag      = operand_a;
  assign b_mag      = operand_b;
`endif

  // One shift-add multiply step and one restoring-divide step, both from current state.
  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [WIDTH-1:0] mul_acc_nx, mul_mq_nx, div_acc_nx, div_mq_nx;

  assign mul_sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
  assign mul_acc_nx = mul_sum[WIDTH:1];
  assign mul_mq_nx  = {mul_sum[0], mq_q[WIDTH-1:1]};
  assign div_sh     = {acc_q, mq_q[WIDTH-1]};
  assign div_diff   = div_sh - {1'b0, b_q};
  assign div_acc_nx = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_mq_nx  = {mq_q[WIDTH-2:0], ~div_diff[WIDTH]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
`ifdef MUL_DIV_SIGNED_EN
    signed_d  = signed_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          cnt_d = '0;
          acc_d = '0;
          mq_d  = op[0] ? a_mag : b_mag;
          b_d   = op[0] ? b_mag : a_mag;
          dbz_d = 1'b0;
`ifdef MUL_DIV_SIGNED_EN
          signed_d  = op[1];
          div_d     = op[0];
          neg_d     = sign_a ^ sign_b;
          rem_neg_d = sign_a;
`endif
          if (op[0] && (operand_b == '0)) begin
            hi_d    = operand_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = op[0] ? StDiv : StMul;
          end
        end else begin
          if (hi_we) hi_d = write_data;
          if (lo_we) lo_d = write_data;
        end
      end
      StMul: begin
        acc_d = mul_acc_nx;
        mq_d  = mul_mq_nx;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          hi_d    = mul_acc_nx;
          lo_d    = mul_mq_nx;
`ifdef MUL_DIV_SIGNED_EN
          if (signed_q) begin
            state_d = StFixup;
            hi_d    = hi_q;
            lo_d    = lo_q;
          end
`endif
        end
      end
      StDiv: begin
        acc_d = div_acc_nx;
        mq_d  = div_mq_nx;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
          hi_d    = div_acc_nx;
          lo_d    = div_mq_nx;
`ifdef MUL_DIV_SIGNED_EN
          if (signed_q) begin
            state_d = StFixup;
            hi_d    = hi_q;
            lo_d    = lo_q;
          end
`endif
        end
      end
`ifdef MUL_DIV_SIGNED_EN
      StFixup: begin
        state_d = StDone;
        if (div_q) begin
          lo_d = neg_q ? -mq_q : mq_q;
          hi_d = rem_neg_q ? -acc_q : acc_q;  // remainder follows the dividend's sign
        end else begin
          {hi_d, lo_d} = neg_q ? prod_neg : prod;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
`ifdef MUL_DIV_SIGNED_EN
      signed_q  <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
`ifdef MUL_DIV_SIGNED_EN
      signed_q  <= signed_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
`endif
    end
  end

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign done        = (state_q == StDone);
  assign div_by_zero = done & dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
